// File: rtl/ins_mem_loader.sv
// Boot-time program loader: receives a length/payload/checksum byte frame and
// writes the payload into instruction memory, releasing the processor once verified.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_WAIT_LEN | ready for the length byte of a new frame
// S_LOAD     | accepting payload bytes, writing each to memory
// S_WAIT_SUM | accepting the checksum byte
// S_DONE     | frame verified, processor running
// S_ERROR    | checksum mismatch or inter-byte timeout, processor held (sticky)
module ins_mem_loader #(
   parameter logic [7:0]  BASE_ADDR   = 8'h00,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       run,
   output logic       error
);

   typedef enum logic [2:0] {
      S_WAIT_LEN,
      S_LOAD,
      S_WAIT_SUM,
      S_DONE,
      S_ERROR
   } state_t;

   localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   // The counter holds the number of idle edges already seen, so the edge that
   // would bring it to TIMEOUT_CYC is the one where it reads TIMEOUT_CYC-1.
   localparam logic [IDLE_W-1:0] IDLE_LAST =
      IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   state_t            state;
   logic [8:0]        len_cnt;
   logic [7:0]        idx;
   logic [7:0]        sum;
   logic [IDLE_W-1:0] idle_cnt;

   logic accept;
   logic timeout_hit;

   assign accept      = in_valid && in_ready;
   assign timeout_hit = (TIMEOUT_CYC != 0) && (idle_cnt == IDLE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_WAIT_LEN;
         len_cnt  <= '0;
         idx      <= '0;
         sum      <= '0;
         idle_cnt <= '0;
         in_ready <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         run      <= 1'b0;
         error    <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            S_WAIT_LEN: begin
               in_ready <= 1'b1;
               if (accept) begin
                  len_cnt  <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                  idx      <= '0;
                  sum      <= '0;
                  idle_cnt <= '0;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  wr_en    <= 1'b1;
                  wr_addr  <= BASE_ADDR + idx;
                  wr_data  <= in_data;
                  idx      <= idx + 8'd1;
                  sum      <= sum + in_data;
                  len_cnt  <= len_cnt - 9'd1;
                  idle_cnt <= '0;
                  if (len_cnt == 9'd1) state <= S_WAIT_SUM;
               end else if (timeout_hit) begin
                  in_ready <= 1'b0;
                  error    <= 1'b1;
                  state    <= S_ERROR;
               end else begin
                  idle_cnt <= idle_cnt + IDLE_W'(1);
               end
            end
            S_WAIT_SUM: begin
               if (accept) begin
                  in_ready <= 1'b0;
                  if (in_data == sum) begin
                     run   <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     error <= 1'b1;
                     state <= S_ERROR;
                  end
               end else if (timeout_hit) begin
                  in_ready <= 1'b0;
                  error    <= 1'b1;
                  state    <= S_ERROR;
               end else begin
                  idle_cnt <= idle_cnt + IDLE_W'(1);
               end
            end
            S_DONE, S_ERROR: begin
               if (start) begin
                  in_ready <= 1'b1;
                  run      <= 1'b0;
                  error    <= 1'b0;
                  state    <= S_WAIT_LEN;
               end
            end
            default: state <= S_WAIT_LEN;
         endcase
      end
   end

endmodule

// File: tb/tb_ins_mem_loader.sv
// Bench for ins_mem_loader: directed frames plus randomized frames checked
// against a queue of expected memory writes and a checksum/length frame model.
module tb_ins_mem_loader;

   localparam logic [7:0] BASE = 8'h80;
   localparam int         TO   = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       run;
   logic       error;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] exp_q[$];
   logic [15:0] exp_w;
   logic [7:0]  pay[256];
   bit          rnd_start = 1'b0;

   ins_mem_loader #(.BASE_ADDR(BASE), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .run(run), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Every observed write must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (rst_n && wr_en) begin
         if (exp_q.size() == 0) begin
            chk("wr_spurious", 32'd1, 32'd0);
         end else begin
            exp_w = exp_q.pop_front();
            chk("wr_addr", {24'd0, wr_addr}, {24'd0, exp_w[15:8]});
            chk("wr_data", {24'd0, wr_data}, {24'd0, exp_w[7:0]});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Returns at 1 time unit after the edge that accepted the byte.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit acc;
      int n;
      in_valid = 1'b0;
      repeat (gap) begin
         if (rnd_start && $urandom_range(3, 0) == 0) start = 1'b1;
         tick();
         start = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      do begin
         acc = in_ready;
         tick();
         n++;
      end while (!acc && n < 50);
      if (!acc) chk("accept_bound", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic run_frame(input int n, input logic [7:0] csum, input int max_gap);
      int  s;
      bit  good;
      s = 0;
      for (int i = 0; i < n; i++) s += pay[i];
      good = (csum == 8'(s % 256));
      send_byte(8'(n % 256), $urandom_range(max_gap, 0));
      for (int i = 0; i < n; i++) begin
         send_byte(pay[i], $urandom_range(max_gap, 0));
         exp_q.push_back({8'((BASE + i) % 256), pay[i]});
      end
      send_byte(csum, $urandom_range(max_gap, 0));
      chk("frame_run", {31'd0, run}, {31'd0, good});
      chk("frame_error", {31'd0, error}, {31'd0, !good});
      chk("frame_ready", {31'd0, in_ready}, 32'd0);
      chk("frame_writes_left", exp_q.size(), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s;
      logic [7:0] c;
      repeat (3) tick();
      chk("rst_outputs", {13'd0, in_ready, wr_en, wr_addr, wr_data, run, error}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rdy_before_edge", {31'd0, in_ready}, 32'd0);
      tick();
      chk("rdy_after_release", {31'd0, in_ready}, 32'd1);

      // Basic three-byte frame.
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
      run_frame(3, 8'h66, 0);

      // Byte held valid in DONE must not be consumed.
      in_valid = 1'b1; in_data = 8'h5A;
      repeat (4) tick();
      chk("done_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("done_hold_run", {31'd0, run}, 32'd1);
      in_valid = 1'b0;

      // Reload from DONE.
      pulse_start();
      chk("reload_run", {31'd0, run}, 32'd0);
      chk("reload_ready", {31'd0, in_ready}, 32'd1);
      pay[0] = 8'hAA;
      run_frame(1, 8'hAA, 0);

      // Length 0 means 256 bytes; addresses wrap past 8'hFF.
      pulse_start();
      for (int i = 0; i < 256; i++) pay[i] = 8'(i);
      run_frame(256, 8'h80, 0);
      chk("wrap_last_addr", {24'd0, wr_addr}, 32'h7F);

      // Bad checksum, sticky error, then recovery.
      pulse_start();
      pay[0] = 8'h01; pay[1] = 8'h02;
      run_frame(2, 8'h04, 0);
      in_valid = 1'b1; in_data = 8'h03;
      repeat (5) tick();
      chk("err_sticky", {30'd0, run, error}, 32'd1);
      in_valid = 1'b0;
      pulse_start();
      chk("err_clear", {30'd0, run, error}, 32'd0);
      chk("err_clear_ready", {31'd0, in_ready}, 32'd1);

      // WAIT_LEN never times out.
      repeat (3 * TO) tick();
      chk("wait_len_no_to", {30'd0, error, in_ready}, 32'd1);

      // Inter-byte timeout: error exactly TO edges after the last acceptance.
      send_byte(8'h04, 0);
      send_byte(8'h9C, 0);
      exp_q.push_back({BASE, 8'h9C});
      repeat (TO - 1) tick();
      chk("to_not_yet", {31'd0, error}, 32'd0);
      tick();
      chk("to_error", {31'd0, error}, 32'd1);
      chk("to_state", {30'd0, run, in_ready}, 32'd0);
      pulse_start();

      // Reset with a write in flight, then a full frame from index 0.
      send_byte(8'h05, 0);
      send_byte(8'hC1, 0);
      exp_q.push_back({BASE, 8'hC1});
      send_byte(8'hC2, 0);
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {13'd0, in_ready, wr_en, wr_addr, wr_data, run, error}, 32'd0);
      exp_q.delete();
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
      s = 0;
      for (int i = 0; i < 5; i++) s += pay[i];
      run_frame(5, 8'(s % 256), 0);

      // Randomized frames with gaps, stray start pulses and corrupted checksums.
      rnd_start = 1'b1;
      for (int f = 0; f < 30; f++) begin
         int n;
         pulse_start();
         chk("rnd_restart_ready", {31'd0, in_ready}, 32'd1);
         n = (f == 7) ? 256 : $urandom_range(24, 1);
         s = 0;
         for (int i = 0; i < n; i++) begin
            pay[i] = 8'($urandom);
            s += pay[i];
         end
         c = 8'(s % 256);
         if ($urandom_range(3, 0) == 0) c = c ^ 8'($urandom_range(255, 1));
         run_frame(n, c, 5);
      end
      rnd_start = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
